// File: rtl/mul_16_23_pkg.sv
// Shared constants for the divide-by-23 pair (divider and reconstruction
// multiplier), plus the FSM state encoding used by the multiplier.
package mul_16_23_pkg;

  localparam int WX   = 16;          // reconstructed dividend width
  localparam int WQ   = 12;          // quotient width
  localparam int WR   = 5;           // remainder width, also D bits scanned
  localparam int D    = 23;          // constant divisor
  localparam int WACC = WQ + WR + 1; // accumulator never wraps for any Q, R
  localparam int WK   = $clog2(WR);  // step counter width

  localparam logic [WR-1:0] D_W    = WR'(D);
  localparam logic [WK-1:0] LAST_K = WK'(WR - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit k of the divisor; written as a scan so an out-of-range k reads 0.
  function automatic logic d_bit(input logic [WK-1:0] k);
    logic b;
    b = 1'b0;
    for (int i = 0; i < WR; i++) begin
      if (k == WK'(i)) b = D_W[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/mul_16_23.sv
// Rebuilds X = Q*D + R from a quotient/remainder pair by scanning the bits
// of the constant divisor, one bit per cycle. Valid/ready on both sides.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a pair; in_ready high
// ACC     | one shift-add step per cycle over D[0..WR-1]
// DONE    | result registered; out_valid high until out_ready
module mul_16_23
  import mul_16_23_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WQ-1:0] Q_in,
  input  logic [WR-1:0] R_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WX-1:0] X_out,
  output logic          ovf,
  output logic          rem_err
);

  state_e            state_q, state_d;
  logic [WK-1:0]     k_q;
  logic [WQ-1:0]     q_q;
  logic [WACC-1:0]   acc_q, acc_d;
  logic [WACC-1:0]   addend;
  logic [WX-1:0]     x_q;
  logic              ovf_q;
  logic              rem_q;
  logic              accept;
  logic              last_step;

  assign accept    = in_valid && (state_q == ST_IDLE);
  assign last_step = (state_q == ST_ACC) && (k_q == LAST_K);

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: fixed WR steps in ACC regardless of which D bits are set.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_ACC;
      ST_ACC:  if (last_step) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs come straight from state, so they are mutually exclusive.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // One shift-add step: add Q<<k when bit k of D is set.
  always_comb begin
    addend = WACC'(q_q) << k_q;
    acc_d  = acc_q;
    if (d_bit(k_q)) acc_d = acc_q + addend;
  end

  // Datapath: load on accept, step in ACC, capture the result on the last step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q   <= '0;
      q_q   <= '0;
      acc_q <= '0;
      x_q   <= '0;
      ovf_q <= 1'b0;
      rem_q <= 1'b0;
    end else begin
      if (accept) begin
        q_q   <= Q_in;
        acc_q <= WACC'(R_in);
        k_q   <= '0;
        rem_q <= (R_in >= D_W);
      end else if (state_q == ST_ACC) begin
        acc_q <= acc_d;
        k_q   <= k_q + WK'(1);
        if (last_step) begin
          x_q   <= acc_d[WX-1:0];
          ovf_q <= |acc_d[WACC-1:WX];
        end
      end
    end
  end

  assign X_out   = x_q;
  assign ovf     = ovf_q;
  assign rem_err = rem_q;

endmodule

// File: tb/tb_mul_16_23.sv
// Directed and random checks of the Q*23+R reconstruction multiplier.
module tb_mul_16_23;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] Q_in;
  logic [4:0]  R_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] X_out;
  logic        ovf;
  logic        rem_err;

  int n_checks = 0;
  int n_pass   = 0;

  mul_16_23 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Q_in      (Q_in),
    .R_in      (R_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .X_out     (X_out),
    .ovf       (ovf),
    .rem_err   (rem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Called #1 after a rising edge; leaves the bench #1 after the accept edge.
  task automatic start_job(input logic [11:0] q, input logic [4:0] r);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("start_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    Q_in     = q;
    R_in     = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) chk("done_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic finish_job();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_job(input string tag, input logic [11:0] q, input logic [4:0] r,
                         input logic [15:0] exp_x, input logic exp_ovf, input logic exp_rem);
    int lat;
    start_job(q, r);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd6);
    chk({tag, "_x"},   32'(X_out), 32'(exp_x));
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    chk({tag, "_rem"}, 32'(rem_err), 32'(exp_rem));
    finish_job();
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    logic [15:0] held_x;
    logic        held_ovf;
    logic        held_rem;
    logic [11:0] rq;
    logic [4:0]  rr;
    int unsigned full;
    int unsigned xv;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; Q_in = '0; R_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_x",         32'(X_out),     32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    chk("rst_rem",       32'(rem_err),   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Hand-computed directed vectors.
    run_job("q100_r5",   12'd100,  5'd5,  16'd2305,  1'b0, 1'b0);
    run_job("q2849_r8",  12'd2849, 5'd8,  16'd65535, 1'b0, 1'b0);
    run_job("q2849_r13", 12'd2849, 5'd13, 16'd4,     1'b1, 1'b0);
    run_job("q4095_r22", 12'd4095, 5'd22, 16'd28671, 1'b1, 1'b0);
    run_job("q0_r0",     12'd0,    5'd0,  16'd0,     1'b0, 1'b0);
    run_job("q10_r23",   12'd10,   5'd23, 16'd253,   1'b0, 1'b1);
    run_job("q10_r3",    12'd10,   5'd3,  16'd233,   1'b0, 1'b0);
    run_job("q4095_r31", 12'd4095, 5'd31, 16'd28680, 1'b1, 1'b1);

    // Stall in DONE with in_valid pushing a different job.
    start_job(12'd7, 5'd1);
    wait_done(lat);
    held_x = X_out; held_ovf = ovf; held_rem = rem_err;
    chk("stall_x0", 32'(held_x), 32'd162);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; Q_in = 12'(i + 300); R_in = 5'(i);
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_x",     32'(X_out), 32'(held_x));
      chk("stall_flags", {30'd0, ovf, rem_err}, {30'd0, held_ovf, held_rem});
    end
    in_valid = 1'b0;
    finish_job();
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_ready", 32'(in_ready), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("ignored_no_job", 32'(out_valid), 32'd0);

    // Reset during ACC.
    start_job(12'd1234, 5'd9);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_x",     32'(X_out), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_result", 32'(out_valid), 32'd0);
    run_job("after_rst", 12'd1234, 5'd9, 16'd28391, 1'b0, 1'b0);

    // Random sweep against the arithmetic reference.
    for (int i = 0; i < 30; i++) begin
      rq   = 12'($urandom_range(0, 4095));
      rr   = 5'($urandom_range(0, 31));
      full = 32'(rq) * 23 + 32'(rr);
      run_job("rand", rq, rr, full[15:0], (full > 32'd65535), (rr >= 5'd23));
    end

    // Divider round trip: X -> (X/23, X%23) -> X.
    for (int i = 0; i < 20; i++) begin
      xv = $urandom_range(0, 65535);
      run_job("roundtrip", 12'(xv / 23), 5'(xv % 23), 16'(xv), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
